ic2: RTL and testbench
======================

Name: ic2

Overview:
- Single-master I2C controller that performs one register-write or register-read transaction per command on an open-drain SDA/SCL pair.
- A 32-bit command word is loaded by a one-cycle strobe from the system bus side.
- Progress and results are reported on a 32-bit status word.
- Sits between a processor/control register block and an off-chip I2C slave; pull-ups are external.

Parameters:
- QDIV, 250: sys_clock cycles per SCL quarter-period (100 MHz / (4*250) = 100 kHz SCL).

Ports:
- sys_clock  input  1  system clock, all logic rising-edge.
- reset  input  1  asynchronous, active-low reset.
- ctrl_data  input  32  command word: [7:0] write data, [15:8] register address, [22:16] 7-bit slave address, [23] ignored, [24] 1=read / 0=write, [31:25] ignored.
- wr_ctrl  input  1  one-cycle command strobe.
- status  output  32  [0] busy, [1] done (sticky), [2] nack (sticky), [15:8] read data, [31:16] and [7:3] zero.
- SDA  inout  1  open-drain data; drives 0 or high-Z only.
- SCL  inout  1  open-drain clock; drives 0 or high-Z only.

Behaviour:
- Reset (async, low): both lines released (Z), state IDLE, status = 0, all counters and shift registers cleared. Reset asserted mid-transfer releases lines immediately, with no STOP issued.
- Command acceptance:
  - In IDLE, wr_ctrl=1 latches ctrl_data on that edge.
  - Same edge: busy<=1, done<=0, nack<=0.
  - Transfer starts next cycle.
  - wr_ctrl while busy is ignored.
- Bit timing: quarter-period tick every QDIV cycles.
  - Each data bit is 4 quarters: SCL low (SDA changes at start of first quarter), low, high, high.
  - SDA is sampled at the end of the first high quarter.
- Clock stretching: after releasing SCL, the tick counter holds while the sampled SCL input is 0.
- START: from SDA=Z, SCL=Z, drive SDA low for 2 quarters, then SCL low.
- Write sequence: START, {addr[6:0],0}, ACK, reg, ACK, data, ACK, STOP.
- Read sequence: START, {addr,0}, ACK, reg, ACK, repeated START, {addr,1}, ACK, 8 bits read (SDA released), master NACK (SDA Z), STOP.
- Bytes are sent MSB first.
- ACK slot: master releases SDA. Sampled 0 = ACK; sampled 1 = NACK.
- On any NACK: set nack=1, skip the remaining bytes, go directly to STOP.
- STOP: SDA low with SCL low, release SCL, wait 2 quarters, release SDA, wait 2 quarters of bus-free time.
- Completion: after STOP, busy<=0 and done<=1 on the same cycle.
  - Read data appears in status[15:8] in that cycle and holds until the next accepted command clears it to 0.
- State machine states: IDLE, START, SEND_BYTE, WAIT_ACK, RSTART, READ_BYTE, SEND_NACK, STOP, DONE.
  - A byte index counter (0..3) selects the next byte and direction.
  - A 3-bit bit counter counts 7 down to 0.
- Line idle level: both lines Z whenever not busy.
- Lines are never driven high.

Test Plan:
- Reset held low, then released, lines pulled up -> SDA=1, SCL=1, status=0x00000000; a wr_ctrl pulse during reset is ignored.
- Write with ctrl_data=0x00665544 and a slave model ACKing everything:
  - Bytes seen on the bus: 0xCC, 0x55, 0x44, each followed by ACK, with START before and STOP after.
  - Status goes to 0x1 (busy), then 0x2 (done).
  - SCL period = 4*QDIV cycles.
- Read with ctrl_data=0x01665500, slave returning 0xA5:
  - Bus sequence: 0xCC, 0x55, repeated START, 0xCD, read byte 0xA5, master NACK, STOP.
  - Final status = 0x0000A502.
- No slave (all ACK slots read 1) with ctrl_data=0x00665544 -> STOP issued right after the address byte; final status = 0x00000006.
- Second wr_ctrl pulse mid-transfer -> ignored; the first transaction completes unchanged. A new command after done clears done/nack at acceptance.
- Slave stretches SCL low for 1000 cycles at the first ACK -> bit timing resumes after release with no lost bits; data is still correct.
- Reset asserted mid-byte -> lines released within the same cycle, status=0.

Source files
------------

// File: rtl/ic2.sv
// Single-master I2C controller: one register write or register read per command word.
// Open-drain SDA/SCL, quarter-period bit timing with SCL clock-stretch support.
`timescale 1ns/1ps

module ic2 #(
   parameter int unsigned QDIV = 250
) (
   input  logic        sys_clock,
   input  logic        reset,
   input  logic [31:0] ctrl_data,
   input  logic        wr_ctrl,
   output logic [31:0] status,
   inout  wire         SDA,
   inout  wire         SCL
);

   localparam int unsigned QW = (QDIV > 1) ? $clog2(QDIV) : 1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_START,
      S_SEND_BYTE,
      S_WAIT_ACK,
      S_RSTART,
      S_READ_BYTE,
      S_SEND_NACK,
      S_STOP,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [QW-1:0]   qcnt_q, qcnt_d;
   logic [2:0]      ph_q, ph_d;
   logic [2:0]      bitcnt_q, bitcnt_d;
   logic [1:0]      bidx_q, bidx_d;
   logic [7:0]      sh_q, sh_d;
   logic [7:0]      rx_q, rx_d;
   logic [6:0]      addr_q, addr_d;
   logic [7:0]      reg_q, reg_d;
   logic [7:0]      wdata_q, wdata_d;
   logic            rd_q, rd_d;
   logic            nak_q, nak_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            nack_q, nack_d;
   logic [7:0]      rdata_q, rdata_d;
   logic            scl_low_q, scl_low_d;
   logic            sda_low_q, sda_low_d;

   logic            sda_in, scl_in;
   logic            stretch, timed, tick;
   logic            load;
   logic [7:0]      lbyte;
   logic            unused_bits;

   assign unused_bits = ^{ctrl_data[31:25], ctrl_data[23]};

   // Open-drain pads: only ever pull low or release.
   assign SDA = sda_low_q ? 1'b0 : 1'bz;
   assign SCL = scl_low_q ? 1'b0 : 1'bz;
   assign sda_in = SDA;
   assign scl_in = SCL;

   assign status = {16'h0000, rdata_q, 5'b00000, nack_q, done_q, busy_q};

   // A released SCL still seen low means the slave is stretching the clock.
   assign stretch = !scl_low_q && !scl_in;
   assign timed   = (state_q != S_IDLE) && (state_q != S_DONE);
   assign tick    = timed && !stretch && (qcnt_q == QW'(QDIV - 1));

   always_comb begin
      state_d   = state_q;
      qcnt_d    = qcnt_q;
      ph_d      = ph_q;
      bitcnt_d  = bitcnt_q;
      bidx_d    = bidx_q;
      sh_d      = sh_q;
      rx_d      = rx_q;
      addr_d    = addr_q;
      reg_d     = reg_q;
      wdata_d   = wdata_q;
      rd_d      = rd_q;
      nak_d     = nak_q;
      busy_d    = busy_q;
      done_d    = done_q;
      nack_d    = nack_q;
      rdata_d   = rdata_q;
      scl_low_d = scl_low_q;
      sda_low_d = sda_low_q;
      load      = 1'b0;
      lbyte     = 8'h00;

      if (timed && !stretch) begin
         qcnt_d = tick ? '0 : qcnt_q + QW'(1);
      end
      if (tick) begin
         ph_d = ph_q + 3'd1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (wr_ctrl) begin
               addr_d    = ctrl_data[22:16];
               reg_d     = ctrl_data[15:8];
               wdata_d   = ctrl_data[7:0];
               rd_d      = ctrl_data[24];
               busy_d    = 1'b1;
               done_d    = 1'b0;
               nack_d    = 1'b0;
               rdata_d   = 8'h00;
               rx_d      = 8'h00;
               nak_d     = 1'b0;
               sda_low_d = 1'b1;
               qcnt_d    = '0;
               ph_d      = 3'd0;
               bidx_d    = 2'd0;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (tick && ph_q == 3'd1) begin
               load  = 1'b1;
               lbyte = {addr_q, 1'b0};
            end
         end
         S_SEND_BYTE: begin
            if (tick && ph_q == 3'd1) begin
               scl_low_d = 1'b0;
            end else if (tick && ph_q == 3'd3) begin
               scl_low_d = 1'b1;
               ph_d      = 3'd0;
               if (bitcnt_q == 3'd0) begin
                  sda_low_d = 1'b0;
                  state_d   = S_WAIT_ACK;
               end else begin
                  bitcnt_d  = bitcnt_q - 3'd1;
                  sh_d      = {sh_q[6:0], 1'b0};
                  sda_low_d = !sh_q[6];
               end
            end
         end
         S_WAIT_ACK: begin
            if (tick && ph_q == 3'd1) begin
               scl_low_d = 1'b0;
            end else if (tick && ph_q == 3'd2) begin
               nak_d = sda_in;
            end else if (tick && ph_q == 3'd3) begin
               scl_low_d = 1'b1;
               ph_d      = 3'd0;
               if (nak_q) begin
                  nack_d    = 1'b1;
                  sda_low_d = 1'b1;
                  state_d   = S_STOP;
               end else begin
                  unique case (bidx_q)
                     2'd0: begin
                        bidx_d = 2'd1;
                        load   = 1'b1;
                        lbyte  = reg_q;
                     end
                     2'd1: begin
                        bidx_d = 2'd2;
                        if (rd_q) begin
                           sda_low_d = 1'b0;
                           state_d   = S_RSTART;
                        end else begin
                           load  = 1'b1;
                           lbyte = wdata_q;
                        end
                     end
                     2'd2: begin
                        if (rd_q) begin
                           bidx_d    = 2'd3;
                           bitcnt_d  = 3'd7;
                           sda_low_d = 1'b0;
                           state_d   = S_READ_BYTE;
                        end else begin
                           sda_low_d = 1'b1;
                           state_d   = S_STOP;
                        end
                     end
                     default: begin
                        sda_low_d = 1'b1;
                        state_d   = S_STOP;
                     end
                  endcase
               end
            end
         end
         S_RSTART: begin
            // Raise SCL with SDA released, then pull SDA low while SCL is high.
            if (tick && ph_q == 3'd1) begin
               scl_low_d = 1'b0;
            end else if (tick && ph_q == 3'd3) begin
               sda_low_d = 1'b1;
            end else if (tick && ph_q == 3'd5) begin
               load  = 1'b1;
               lbyte = {addr_q, 1'b1};
            end
         end
         S_READ_BYTE: begin
            if (tick && ph_q == 3'd1) begin
               scl_low_d = 1'b0;
            end else if (tick && ph_q == 3'd2) begin
               rx_d = {rx_q[6:0], sda_in};
            end else if (tick && ph_q == 3'd3) begin
               scl_low_d = 1'b1;
               ph_d      = 3'd0;
               if (bitcnt_q == 3'd0) begin
                  state_d = S_SEND_NACK;
               end else begin
                  bitcnt_d = bitcnt_q - 3'd1;
               end
            end
         end
         S_SEND_NACK: begin
            if (tick && ph_q == 3'd1) begin
               scl_low_d = 1'b0;
            end else if (tick && ph_q == 3'd3) begin
               scl_low_d = 1'b1;
               sda_low_d = 1'b1;
               ph_d      = 3'd0;
               state_d   = S_STOP;
            end
         end
         S_STOP: begin
            if (tick && ph_q == 3'd1) begin
               scl_low_d = 1'b0;
            end else if (tick && ph_q == 3'd3) begin
               sda_low_d = 1'b0;
            end else if (tick && ph_q == 3'd5) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            rdata_d = rx_q;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Start of a new outgoing byte: SCL low and MSB on SDA in the same cycle.
      if (load) begin
         state_d   = S_SEND_BYTE;
         sh_d      = lbyte;
         sda_low_d = !lbyte[7];
         scl_low_d = 1'b1;
         bitcnt_d  = 3'd7;
         ph_d      = 3'd0;
      end
   end

   always_ff @(posedge sys_clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         qcnt_q    <= '0;
         ph_q      <= 3'd0;
         bitcnt_q  <= 3'd0;
         bidx_q    <= 2'd0;
         sh_q      <= 8'h00;
         rx_q      <= 8'h00;
         addr_q    <= 7'h00;
         reg_q     <= 8'h00;
         wdata_q   <= 8'h00;
         rd_q      <= 1'b0;
         nak_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         nack_q    <= 1'b0;
         rdata_q   <= 8'h00;
         scl_low_q <= 1'b0;
         sda_low_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         qcnt_q    <= qcnt_d;
         ph_q      <= ph_d;
         bitcnt_q  <= bitcnt_d;
         bidx_q    <= bidx_d;
         sh_q      <= sh_d;
         rx_q      <= rx_d;
         addr_q    <= addr_d;
         reg_q     <= reg_d;
         wdata_q   <= wdata_d;
         rd_q      <= rd_d;
         nak_q     <= nak_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         nack_q    <= nack_d;
         rdata_q   <= rdata_d;
         scl_low_q <= scl_low_d;
         sda_low_q <= sda_low_d;
      end
   end

endmodule

// File: tb/tb_ic2.sv
// Bench for ic2: bus monitor + I2C slave model, vector table and random commands
// checked against a transaction-level model of the expected bus traffic.
`timescale 1ns/1ps

module tb_ic2;

   localparam int unsigned QDIV     = 8;
   localparam int          EV_START = 32'h1000;
   localparam int          EV_STOP  = 32'h2000;

   typedef struct packed {
      logic [31:0] cmd;
      logic [3:0]  mask;
      logic [7:0]  rdata;
      logic        stretch;
      logic [31:0] exp;
   } vec_t;

   logic        sys_clock;
   logic        reset;
   logic [31:0] ctrl_data;
   logic        wr_ctrl;
   logic [31:0] status;
   wire         SDA;
   wire         SCL;

   logic        s_sda_low = 1'b0;
   logic        s_scl_low = 1'b0;
   logic [3:0]  ack_mask  = 4'hF;
   logic [7:0]  rdata_s   = 8'h00;
   logic        stretch_en = 1'b0;

   int ev_q[$];
   int rise_q[$];
   int exp_q[$];
   int ev_base, rise_base;
   int cyc = 0;
   int clr_req = 0;
   int n_checks = 0;
   int n_fail = 0;

   pullup (SDA);
   pullup (SCL);
   assign SDA = s_sda_low ? 1'b0 : 1'bz;
   assign SCL = s_scl_low ? 1'b0 : 1'bz;

   ic2 #(.QDIV(QDIV)) dut (
      .sys_clock (sys_clock),
      .reset     (reset),
      .ctrl_data (ctrl_data),
      .wr_ctrl   (wr_ctrl),
      .status    (status),
      .SDA       (SDA),
      .SCL       (SCL)
   );

   initial sys_clock = 1'b0;
   always #5 sys_clock = ~sys_clock;
   always @(posedge sys_clock) cyc <= cyc + 1;

   // Bus monitor and slave, sampling the lines once per cycle on the falling clock edge.
   int       nb = 0, frame = 0, hold = 0, clr_seen = 0;
   logic [8:0] sh = 9'h0;
   logic     first = 1'b0, is_read = 1'b0, p_scl = 1'b1, p_sda = 1'b1;

   always @(negedge sys_clock) begin
      if (clr_req != clr_seen) begin
         clr_seen = clr_req;
         nb = 0; frame = 0; hold = 0; first = 1'b0; is_read = 1'b0;
         s_sda_low = 1'b0; s_scl_low = 1'b0;
      end else begin
         if (hold > 0) begin
            hold = hold - 1;
            if (hold == 0) s_scl_low = 1'b0;
         end
         if (p_scl && SCL && p_sda && !SDA) begin
            ev_q.push_back(EV_START);
            nb = 0; sh = 9'h0; first = 1'b1; is_read = 1'b0;
         end else if (p_scl && SCL && !p_sda && SDA) begin
            ev_q.push_back(EV_STOP);
            nb = 0; frame = 0; first = 1'b0; is_read = 1'b0; s_sda_low = 1'b0;
         end else if (!p_scl && SCL) begin
            rise_q.push_back(cyc);
            sh = {sh[7:0], SDA};
            nb = nb + 1;
            if (nb == 9) begin
               ev_q.push_back(32'(sh));
               is_read = first && sh[1] && !sh[0];
               first = 1'b0;
               frame = frame + 1;
               nb = 0;
            end
         end else if (p_scl && !SCL) begin
            if (is_read) s_sda_low = (nb < 8) ? !rdata_s[3'(7 - nb)] : 1'b0;
            else         s_sda_low = (nb == 8 && frame < 4) ? ack_mask[2'(frame)] : 1'b0;
            if (nb == 8 && frame == 0 && !is_read && stretch_en) begin
               s_scl_low = 1'b1;
               hold = 1000;
            end
         end
      end
      p_scl = SCL;
      p_sda = SDA;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   function automatic int frame_code(input logic [7:0] b, input logic ackb);
      return 32'({b, ackb});
   endfunction

   // Expected bus traffic and final status of one command, from the protocol rules.
   task automatic build_expected(input logic [31:0] cmd, input logic [3:0] m,
                                 input logic [7:0] rd, output logic [31:0] st);
      logic [6:0] a;
      a = cmd[22:16];
      exp_q.delete();
      exp_q.push_back(EV_START);
      st = 32'h6;
      exp_q.push_back(frame_code({a, 1'b0}, !m[0]));
      if (!m[0]) begin exp_q.push_back(EV_STOP); return; end
      exp_q.push_back(frame_code(cmd[15:8], !m[1]));
      if (!m[1]) begin exp_q.push_back(EV_STOP); return; end
      if (!cmd[24]) begin
         exp_q.push_back(frame_code(cmd[7:0], !m[2]));
         exp_q.push_back(EV_STOP);
         st = m[2] ? 32'h2 : 32'h6;
         return;
      end
      exp_q.push_back(EV_START);
      exp_q.push_back(frame_code({a, 1'b1}, !m[2]));
      if (!m[2]) begin exp_q.push_back(EV_STOP); return; end
      exp_q.push_back(frame_code(rd, 1'b1));
      exp_q.push_back(EV_STOP);
      st = {16'h0, rd, 8'h02};
   endtask

   task automatic check_events(input string tag);
      int got;
      got = ev_q.size() - ev_base;
      check({tag, "_evcount"}, 32'(got), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got; i++)
         check({tag, "_ev"}, 32'(ev_q[ev_base + i]), 32'(exp_q[i]));
   endtask

   task automatic run_txn(input logic [31:0] cmd, input logic [3:0] m, input logic [7:0] rd,
                          input logic st, input logic inject, output logic [31:0] fin);
      int n;
      ack_mask = m; rdata_s = rd; stretch_en = st;
      ev_base = ev_q.size(); rise_base = rise_q.size();
      @(negedge sys_clock);
      ctrl_data = cmd; wr_ctrl = 1'b1;
      @(negedge sys_clock);
      wr_ctrl = 1'b0;
      check("accept_status", status, 32'h1);
      n = 0;
      while (status[0] === 1'b1 && n < 20000) begin
         @(negedge sys_clock);
         n++;
         wr_ctrl = inject && (n == 300);
         if (inject && n == 300) ctrl_data = ~cmd;
      end
      wr_ctrl = 1'b0;
      check("done_timeout", 32'(status[0]), 32'h0);
      fin = status;
      repeat (3) @(negedge sys_clock);
      check("idle_lines", {30'h0, SDA, SCL}, 32'h3);
   endtask

   vec_t        vecs [0:6];
   logic [31:0] fin, st;

   initial begin
      vecs[0] = '{cmd: 32'h00665544, mask: 4'hF, rdata: 8'h00, stretch: 1'b0, exp: 32'h00000002};
      vecs[1] = '{cmd: 32'h01665500, mask: 4'hF, rdata: 8'hA5, stretch: 1'b0, exp: 32'h0000A502};
      vecs[2] = '{cmd: 32'h00665544, mask: 4'h0, rdata: 8'h00, stretch: 1'b0, exp: 32'h00000006};
      vecs[3] = '{cmd: 32'h00665544, mask: 4'hF, rdata: 8'h00, stretch: 1'b1, exp: 32'h00000002};
      vecs[4] = '{cmd: 32'h01123400, mask: 4'h1, rdata: 8'h3C, stretch: 1'b0, exp: 32'h00000006};
      vecs[5] = '{cmd: 32'h01123400, mask: 4'h3, rdata: 8'h3C, stretch: 1'b0, exp: 32'h00000006};
      vecs[6] = '{cmd: 32'hFE7F00FF, mask: 4'h3, rdata: 8'h00, stretch: 1'b0, exp: 32'h00000006};

      reset = 1'b0; wr_ctrl = 1'b0; ctrl_data = 32'h0;
      repeat (3) @(negedge sys_clock);
      ctrl_data = 32'h00665544; wr_ctrl = 1'b1;
      @(negedge sys_clock);
      wr_ctrl = 1'b0;
      repeat (2) @(negedge sys_clock);
      reset = 1'b1;
      repeat (5) @(negedge sys_clock);
      check("reset_status", status, 32'h0);
      check("reset_lines", {30'h0, SDA, SCL}, 32'h3);

      for (int i = 0; i < 7; i++) begin
         build_expected(vecs[i].cmd, vecs[i].mask, vecs[i].rdata, st);
         run_txn(vecs[i].cmd, vecs[i].mask, vecs[i].rdata, vecs[i].stretch, 1'b0, fin);
         check("vec_status", fin, vecs[i].exp);
         check_events("vec");
         check("scl_period", 32'(rise_q[rise_base + 1] - rise_q[rise_base]), 32'(4 * QDIV));
         if (vecs[i].stretch) begin
            check("stretch_held", 32'(rise_q[rise_base + 8] - rise_q[rise_base + 7] >= 900), 32'h1);
            check("post_stretch_period",
                  32'(rise_q[rise_base + 10] - rise_q[rise_base + 9]), 32'(4 * QDIV));
         end else begin
            check("ack_period", 32'(rise_q[rise_base + 8] - rise_q[rise_base + 7]), 32'(4 * QDIV));
         end
      end

      // Second strobe while busy must not disturb the running transfer.
      build_expected(32'h01665500, 4'hF, 8'h5A, st);
      run_txn(32'h01665500, 4'hF, 8'h5A, 1'b0, 1'b1, fin);
      check("inject_status", fin, st);
      check_events("inject");

      for (int i = 0; i < 12; i++) begin
         logic [31:0] c;
         logic [3:0]  m;
         logic [7:0]  r;
         c = $urandom();
         m = 4'($urandom_range(0, 15));
         r = 8'($urandom());
         build_expected(c, m, r, st);
         run_txn(c, m, r, 1'b0, 1'b0, fin);
         check("rand_status", fin, st);
         check_events("rand");
      end

      // Reset in the middle of a byte, while the master holds both lines low.
      ack_mask = 4'hF; stretch_en = 1'b0;
      @(negedge sys_clock);
      ctrl_data = 32'h00665544; wr_ctrl = 1'b1;
      @(negedge sys_clock);
      wr_ctrl = 1'b0;
      repeat (83) @(negedge sys_clock);
      check("pre_abort_lines", {30'h0, SDA, SCL}, 32'h0);
      @(posedge sys_clock);
      #3 reset = 1'b0;
      #1;
      check("abort_lines", {30'h0, SDA, SCL}, 32'h3);
      check("abort_status", status, 32'h0);
      clr_req++;
      repeat (3) @(negedge sys_clock);
      reset = 1'b1;
      repeat (3) @(negedge sys_clock);

      build_expected(vecs[1].cmd, vecs[1].mask, vecs[1].rdata, st);
      run_txn(vecs[1].cmd, vecs[1].mask, vecs[1].rdata, 1'b0, 1'b0, fin);
      check("recover_status", fin, 32'h0000A502);
      check_events("recover");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
